// File: rtl/fsmc_regbank_ctrl_pkg.sv
// fsmc_regbank_ctrl_pkg: shared op codes, FSM states and counter width for the register bank controller
package fsmc_regbank_ctrl_pkg;
  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_ADD, OP_OR} op_e;
  typedef enum logic [1:0] {IDLE, RD, WB, ACK} state_e;
  localparam int CNT_W = 8;
endpackage

// File: rtl/fsmc_regbank_ctrl_alu.sv
// fsmc_regbank_ctrl_alu: combinational result of an internal op applied to the fetched operand
module fsmc_regbank_ctrl_alu
  import fsmc_regbank_ctrl_pkg::*;
#(
  parameter int DW = 3
) (
  input  op_e           op,
  input  logic [DW-1:0] opnd,
  input  logic [DW-1:0] data,
  output logic [DW-1:0] result
);
  assign result = op == OP_ADD ? opnd + data : op == OP_OR ? opnd | data : data;
endmodule

// File: rtl/fsmc_regbank_ctrl.sv
// fsmc_regbank_ctrl: FSMC register bank whose write port is shared by the bus slave and one internal requester
module fsmc_regbank_ctrl
  import fsmc_regbank_ctrl_pkg::*;
#(
  parameter int AW        = 2,
  parameter int DW        = 3,
  parameter int RETRY_MAX = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   bus_do_write,
  input  logic [AW-1:0]          bus_w_adr,
  input  logic [DW-1:0]          bus_w_data,
  input  logic [AW-1:0]          bus_r_adr,
  output logic [DW-1:0]          bus_r_data,
  input  logic                   int_req,
  input  logic [1:0]             int_op,
  input  logic [AW-1:0]          int_adr,
  input  logic [DW-1:0]          int_data,
  output logic                   int_ack,
  output logic                   int_err,
  output logic [DW-1:0]          int_rdata,
  output logic                   int_busy,
  output logic [(1<<AW)*DW-1:0]  reg_q,
  output logic [CNT_W-1:0]       conflict_cnt
);
  localparam int NREG = 1 << AW;
  logic [DW-1:0] regs [NREG];
  state_e state;
  op_e op;
  logic [AW-1:0] adr;
  logic [DW-1:0] data, opnd, result;
  logic [CNT_W-1:0] retry;
  logic hit, coll, last, done, int_we;
  assign hit = bus_do_write && bus_w_adr == adr;
  assign coll = hit && (state == RD || (state == WB && op != OP_READ));
  assign last = retry == CNT_W'(RETRY_MAX - 1);
  assign done = state == WB && (op == OP_READ || !bus_do_write);
  assign int_we = done && op != OP_READ;
  assign int_busy = state != IDLE;
  assign bus_r_data = regs[bus_r_adr];
  for (genvar i = 0; i < NREG; i++) begin : g_q
    assign reg_q[i*DW +: DW] = regs[i];
  end
  fsmc_regbank_ctrl_alu #(.DW(DW)) u_alu (
    .op     (op),
    .opnd   (opnd),
    .data   (data),
    .result (result)
  );
  // Bus write always wins; the internal write only lands in a cycle without a bus strobe
  always_ff @(posedge clk)
    if (rst) regs <= '{default: '0};
    else if (bus_do_write) regs[bus_w_adr] <= bus_w_data;
    else if (int_we) regs[adr] <= result;
  // Internal-op FSM: fetch in RD, commit in WB, retry on same-address bus writes, pulse ack from ACK
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op <= OP_READ;
      adr <= '0;
      data <= '0;
      opnd <= '0;
      retry <= '0;
      int_ack <= 1'b0;
      int_err <= 1'b0;
      int_rdata <= '0;
      conflict_cnt <= '0;
    end else begin
      int_ack <= 1'b0;
      int_err <= 1'b0;
      if (coll) begin
        retry <= retry + 1'b1;
        conflict_cnt <= conflict_cnt == '1 ? conflict_cnt : conflict_cnt + 1'b1;
      end
      if (state == RD) opnd <= regs[adr];
      if (coll && last) begin
        state <= ACK;
        int_ack <= 1'b1;
        int_err <= 1'b1;
        int_rdata <= opnd;
      end else if (done) begin
        state <= ACK;
        int_ack <= 1'b1;
        int_rdata <= opnd;
      end else begin
        case (state)
          IDLE: if (int_req) begin
            state <= RD;
            op <= op_e'(int_op);
            adr <= int_adr;
            data <= int_data;
            retry <= '0;
          end
          RD: state <= hit ? RD : WB;
          WB: state <= hit ? RD : WB;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fsmc_regbank_ctrl.sv
// tb_fsmc_regbank_ctrl: directed scenarios plus random traffic checked against a transaction-level model
module tb_fsmc_regbank_ctrl;
  localparam int AW = 2, DW = 3, NREG = 4, RMAX = 7;
  logic clk = 0, rst = 1;
  logic bus_do_write = 0, int_req = 0;
  logic [AW-1:0] bus_w_adr = 0, bus_r_adr = 0, int_adr = 0;
  logic [DW-1:0] bus_w_data = 0, int_data = 0;
  logic [1:0] int_op = 0;
  logic [DW-1:0] bus_r_data, int_rdata;
  logic int_ack, int_err, int_busy;
  logic [NREG*DW-1:0] reg_q;
  logic [7:0] conflict_cnt;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  fsmc_regbank_ctrl #(.AW(AW), .DW(DW), .RETRY_MAX(RMAX)) dut (
    .clk(clk), .rst(rst), .bus_do_write(bus_do_write), .bus_w_adr(bus_w_adr),
    .bus_w_data(bus_w_data), .bus_r_adr(bus_r_adr), .bus_r_data(bus_r_data),
    .int_req(int_req), .int_op(int_op), .int_adr(int_adr), .int_data(int_data),
    .int_ack(int_ack), .int_err(int_err), .int_rdata(int_rdata), .int_busy(int_busy),
    .reg_q(reg_q), .conflict_cnt(conflict_cnt)
  );
  // Model: an op is a series of attempts, each a fetch cycle then a commit cycle, then one ack cycle
  logic [DW-1:0] mr [NREG];
  int mcnt = 0, mtries = 0, phase = 0;
  logic [1:0] mop = 0;
  logic [AW-1:0] madr = 0;
  logic [DW-1:0] mdat = 0, mopnd = 0, mrd = 0;
  logic mack = 0, merr = 0, mhit;
  function automatic logic [DW-1:0] apply(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (op == 2) return DW'((int'(a) + int'(b)) % (1 << DW));
    if (op == 3) return a | b;
    return b;
  endfunction
  task automatic collide();
    mtries++;
    if (mcnt < 255) mcnt++;
    if (mtries == RMAX) begin
      mack = 1;
      merr = 1;
      phase = 3;
    end else phase = 1;
  endtask
  task automatic finish_ok();
    mack = 1;
    mrd = mopnd;
    phase = 3;
  endtask
  always @(posedge clk) begin
    if (rst) begin
      foreach (mr[i]) mr[i] = 0;
      mcnt = 0;
      phase = 0;
      mack = 0;
      merr = 0;
      mrd = 0;
    end else begin
      mack = 0;
      merr = 0;
      mhit = bus_do_write && bus_w_adr == madr;
      if (phase == 3) phase = 0;
      else if (phase == 0) begin
        if (int_req) begin
          mop = int_op;
          madr = int_adr;
          mdat = int_data;
          mtries = 0;
          phase = 1;
        end
      end else if (phase == 1) begin
        mopnd = mr[madr];
        if (mhit) collide();
        else phase = 2;
      end else if (mop == 0) finish_ok();
      else if (mhit) collide();
      else if (!bus_do_write) begin
        mr[madr] = apply(mop, mopnd, mdat);
        finish_ok();
      end
      if (bus_do_write) mr[bus_w_adr] = bus_w_data;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic check_all();
    chk("bus_r_data", bus_r_data, mr[bus_r_adr]);
    for (int i = 0; i < NREG; i++) chk($sformatf("reg%0d", i), reg_q[i*DW +: DW], mr[i]);
    chk("int_ack", int_ack, mack);
    chk("int_busy", int_busy, phase != 0);
    chk("conflict_cnt", conflict_cnt, mcnt);
    if (mack) chk("int_err", int_err, merr);
    if (mack && !merr) chk("int_rdata", int_rdata, mrd);
  endtask
  task automatic cyc();
    @(negedge clk);
    check_all();
  endtask
  task automatic req(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int_req = 1;
    int_op = op;
    int_adr = a;
    int_data = d;
  endtask
  task automatic wait_ack(input int start, output int n);
    n = start;
    do begin
      cyc();
      n++;
    end while (!int_ack && n < 40);
  endtask
  initial begin
    int n;
    cyc();
    cyc();
    rst = 0;
    cyc();
    chk("rst_regs", reg_q, 0);
    chk("rst_cnt", conflict_cnt, 0);
    chk("rst_ack", int_ack, 0);
    chk("rst_rdata", int_rdata, 0);
    chk("rst_busy", int_busy, 0);
    bus_do_write = 1; bus_w_adr = 1; bus_w_data = 5; bus_r_adr = 1;
    cyc();
    bus_do_write = 0;
    chk("t1_bus_read", bus_r_data, 5);
    bus_do_write = 1; bus_w_adr = 0; bus_w_data = 6;
    cyc();
    bus_do_write = 0;
    req(2, 0, 3);
    wait_ack(0, n);
    int_req = 0;
    chk("t2_latency", n, 3);
    chk("t2_rdata", int_rdata, 6);
    chk("t2_err", int_err, 0);
    chk("t2_reg0_wrap", reg_q[2:0], 1);
    cyc();
    req(1, 2, 4);
    cyc();
    cyc();
    bus_do_write = 1; bus_w_adr = 2; bus_w_data = 7;
    cyc();
    bus_do_write = 0;
    wait_ack(3, n);
    int_req = 0;
    chk("t3_latency", n, 5);
    chk("t3_reg2", reg_q[8:6], 4);
    chk("t3_cnt", conflict_cnt, 1);
    chk("t3_rdata", int_rdata, 7);
    cyc();
    bus_do_write = 1; bus_w_adr = 3; bus_w_data = 2;
    cyc();
    bus_do_write = 0;
    req(3, 3, 5);
    cyc();
    cyc();
    bus_do_write = 1; bus_w_adr = 1; bus_w_data = 3;
    cyc();
    bus_do_write = 0;
    wait_ack(3, n);
    int_req = 0;
    chk("t4_latency", n, 4);
    chk("t4_reg1", reg_q[5:3], 3);
    chk("t4_reg3", reg_q[11:9], 7);
    chk("t4_cnt", conflict_cnt, 1);
    chk("t4_rdata", int_rdata, 2);
    cyc();
    req(2, 0, 1);
    bus_do_write = 1; bus_w_adr = 0;
    for (int k = 0; k < 8; k++) begin
      bus_w_data = DW'(k);
      cyc();
    end
    bus_do_write = 0;
    int_req = 0;
    chk("t5_ack", int_ack, 1);
    chk("t5_err", int_err, 1);
    chk("t5_reg0", reg_q[2:0], 7);
    chk("t5_cnt", conflict_cnt, 8);
    cyc();
    req(1, 1, 6);
    cyc();
    cyc();
    rst = 1;
    int_req = 0;
    cyc();
    chk("t6_regs", reg_q, 0);
    chk("t6_cnt", conflict_cnt, 0);
    chk("t6_busy", int_busy, 0);
    chk("t6_ack", int_ack, 0);
    rst = 0;
    cyc();
    chk("t6_noack", int_ack, 0);
    chk("t6_nowrite", reg_q, 0);
    for (int c = 0; c < 2000; c++) begin
      cyc();
      if (!int_req || mack) begin
        if ($urandom_range(0, 2) == 0) req(2'($urandom), AW'($urandom), DW'($urandom));
        else int_req = 0;
      end else if ($urandom_range(0, 40) == 0) int_req = 0;
      bus_do_write = $urandom_range(0, 2) == 0;
      bus_w_adr = $urandom_range(0, 1) == 0 ? int_adr : AW'($urandom);
      bus_w_data = DW'($urandom);
      bus_r_adr = AW'($urandom);
      rst = $urandom_range(0, 300) == 0;
    end
    rst = 0;
    for (int c = 0; c < 600; c++) begin
      cyc();
      if (!int_req || mack) req(2'($urandom), AW'($urandom), DW'($urandom));
      bus_do_write = $urandom_range(0, 9) != 0;
      bus_w_adr = int_adr;
      bus_w_data = DW'($urandom);
      bus_r_adr = AW'($urandom);
    end
    cyc();
    chk("cnt_saturated", conflict_cnt, 255);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
